// File: rtl/wbx_pkg.sv
// Shared Wishbone widths and the lock encoding used by the single-master decoder.
package wbx_pkg;

  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  // Lock holds a slave index (0..15) or UNMAPPED, so one extra bit is needed
  localparam int unsigned        LOCK_W        = 5;
  localparam logic [LOCK_W-1:0]  LOCK_UNMAPPED = 5'h10;

endpackage

// File: rtl/wbx_1master_decode_if.sv
// Bus bundle between the Wishbone master, the decoder and the peripheral slaves.
interface wbx_1master_decode_if
  import wbx_pkg::*;
#(
  parameter int unsigned PERIPH_NUM = 2,
  parameter int unsigned ADR_W      = 4
);

  logic                           wbm_cyc_o;
  logic                           wbm_stb_o;
  logic                           wbm_we_o;
  logic [31:0]                    wbm_adr_o;
  logic [WB_SEL_W-1:0]            wbm_sel_o;
  logic [WB_DAT_W-1:0]            wbm_dat_o;
  logic [WB_DAT_W-1:0]            wbm_dat_i;
  logic                           wbm_ack_i;
  logic                           wbm_err_i;
  logic                           wbm_stall_i;

  logic [PERIPH_NUM-1:0]          wbs_cyc_i;
  logic                           wbs_stb_i;
  logic                           wbs_we_i;
  logic [ADR_W-1:0]               wbs_adr_i;
  logic [WB_SEL_W-1:0]            wbs_sel_i;
  logic [WB_DAT_W-1:0]            wbs_dat_i;
  logic [WB_DAT_W*PERIPH_NUM-1:0] wbs_dat_o;
  logic [PERIPH_NUM-1:0]          wbs_stall_o;
  logic [PERIPH_NUM-1:0]          wbs_ack_o;

  // Environment view: the upstream master plus the peripheral slaves
  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_stall_i,
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
    output wbs_dat_o, wbs_stall_o, wbs_ack_o
  );

  // Decoder view: slave of the master, fan-out towards the peripherals
  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_stall_i,
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
    input  wbs_dat_o, wbs_stall_o, wbs_ack_o
  );

endinterface

// File: rtl/wbx_watchdog.sv
// Bus watchdog: counts idle BUSY cycles and raises a one-cycle abort at the limit.
module wbx_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic busy_i,
  input  logic ret_i,
  input  logic accept_i,
  output logic fire_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign fire_c_o = busy_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Any forward progress (accept or return) restarts the count
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i | ~busy_i | ret_i | accept_i | fire_c_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wbx_1master_decode.sv
// Single-master, N-slave Wishbone B4 pipelined decoder with outstanding-request lock.
// Optional bus watchdog built when WBX_TIMEOUT_EN is defined.
module wbx_1master_decode
  import wbx_pkg::*;
#(
  parameter int unsigned PERIPH_NUM     = 2,
  parameter int unsigned ADR_W          = 4,
  parameter int unsigned IDX_W          = 4,
  parameter int unsigned MAX_PENDING    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  wbx_1master_decode_if.slave  bus
);

  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned IDX_LO = ADR_W;
  localparam int unsigned IDX_HI = ADR_W + IDX_W - 1;

  logic [PEND_W-1:0]     pending_q, pending_d;
  logic [LOCK_W-1:0]     lock_q, lock_d;
  logic                  err_q, err_d;

  logic                  cyc, stb, busy, conflict, full, local_stall;
  logic                  slv_stall, slv_ack, stall, accept, ret, wd_fire;
  logic [IDX_W-1:0]      idx;
  logic [LOCK_W-1:0]     idx_lock, target;
  logic [WB_DAT_W-1:0]   lock_dat;
  logic [PERIPH_NUM-1:0] tgt_onehot;

  // Reset also silences every output combinationally
  assign cyc      = bus.wbm_cyc_o & wb_rst_ni;
  assign stb      = cyc & bus.wbm_stb_o;
  assign idx      = bus.wbm_adr_o[IDX_HI:IDX_LO];
  assign idx_lock = (32'(idx) < PERIPH_NUM) ? LOCK_W'(idx) : LOCK_UNMAPPED;
  assign busy     = (pending_q != '0);
  assign target   = busy ? lock_q : idx_lock;
  assign conflict = busy & stb & (idx_lock != lock_q);
  assign full     = (pending_q == PEND_W'(MAX_PENDING));

  // Per-slave selects: target drives the request side, lock drives the return side
  always_comb begin
    tgt_onehot = '0;
    slv_stall  = 1'b0;
    slv_ack    = 1'b0;
    lock_dat   = '0;
    for (int k = 0; k < int'(PERIPH_NUM); k++) begin
      if (target == LOCK_W'(k)) begin
        tgt_onehot[k] = 1'b1;
        slv_stall     = bus.wbs_stall_o[k];
      end
      if (lock_q == LOCK_W'(k)) begin
        slv_ack  = bus.wbs_ack_o[k];
        lock_dat = bus.wbs_dat_o[WB_DAT_W*k +: WB_DAT_W];
      end
    end
  end

  assign local_stall = conflict | full | wd_fire;
  assign stall       = stb & (local_stall | slv_stall);
  assign accept      = stb & ~stall;
  assign ret         = bus.wbm_ack_i | (cyc & err_q);

  assign bus.wbm_stall_i = stall;
  assign bus.wbm_ack_i   = cyc & busy & slv_ack & ~wd_fire;
  assign bus.wbm_err_i   = cyc & (err_q | wd_fire);
  assign bus.wbm_dat_i   = (cyc & busy) ? lock_dat : '0;

  // Slaves only see a strobe the decoder itself is willing to accept
  assign bus.wbs_cyc_i = (cyc & ~wd_fire) ? tgt_onehot : '0;
  assign bus.wbs_stb_i = stb & ~local_stall;
  assign bus.wbs_we_i  = cyc & bus.wbm_we_o;
  assign bus.wbs_adr_i = cyc ? bus.wbm_adr_o[ADR_W-1:0] : '0;
  assign bus.wbs_sel_i = cyc ? bus.wbm_sel_o : '0;
  assign bus.wbs_dat_i = cyc ? bus.wbm_dat_o : '0;

  if (IDX_HI < 31) begin : g_unused_adr
    logic unused_adr_hi;
    assign unused_adr_hi = ^bus.wbm_adr_o[31:IDX_HI+1];
  end

`ifdef WBX_TIMEOUT_EN
  wbx_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .clr_i    (~cyc),
    .busy_i   (busy),
    .ret_i    (ret),
    .accept_i (accept),
    .fire_c_o (wd_fire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign wd_fire        = 1'b0;
`endif

  always_comb begin
    pending_d = pending_q;
    lock_d    = lock_q;
    err_d     = 1'b0;
    if (!cyc || wd_fire) begin
      pending_d = '0;
      lock_d    = '0;
    end else begin
      pending_d = pending_q + PEND_W'(accept) - PEND_W'(ret);
      if (accept && !busy) begin
        lock_d = idx_lock;
      end
      err_d = accept & (target == LOCK_UNMAPPED);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pending_q <= '0;
      lock_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_wbx_1master_decode.sv
// Directed bench for wbx_1master_decode (PERIPH_NUM=2, ADR_W=4, IDX_W=4, MAX_PENDING=4).
module tb_wbx_1master_decode;
  import wbx_pkg::*;

  localparam int unsigned PN = 2;
  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [63:0] s_dat;
  logic [1:0]  s_stall, man_ack;
  logic        auto_en = 1'b0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_dat = '0;
  logic [7:0]  hist = '0;
  int          auto_seq = 0;

  int n_checks, n_errs;
  int issued, acks, err_at;
  int exp_acc[6] = '{0, 1, 2, 3, 7, 8};
  int acc_at[6];
`ifndef WBX_TIMEOUT_EN
  int err_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  wbx_1master_decode_if #(.PERIPH_NUM(PN), .ADR_W(AW)) bus ();

  assign bus.wbm_cyc_o   = cyc;
  assign bus.wbm_stb_o   = stb;
  assign bus.wbm_we_o    = we;
  assign bus.wbm_adr_o   = adr;
  assign bus.wbm_sel_o   = sel;
  assign bus.wbm_dat_o   = wdat;
  assign bus.wbs_dat_o   = auto_ack ? {s_dat[63:32], auto_dat} : s_dat;
  assign bus.wbs_ack_o   = man_ack | {1'b0, auto_ack};
  assign bus.wbs_stall_o = s_stall;

  wbx_1master_decode #(
    .PERIPH_NUM     (PN),
    .ADR_W          (AW),
    .IDX_W          (4),
    .MAX_PENDING    (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus.slave)
  );

  // Slave 0 model: acks each accepted request 6 cycles later with a sequence number
  always @(negedge clk) begin
    auto_ack = auto_en & hist[5];
    if (auto_ack) begin
      auto_dat = 32'h1000 + 32'(auto_seq);
      auto_seq++;
    end
    #2;
    hist = {hist[6:0], auto_en & bus.wbs_cyc_i[0] & stb & ~bus.wbm_stall_i};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    n_checks = 0; n_errs = 0;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0; s_dat = '0; s_stall = '0; man_ack = '0;

    @(negedge clk); #1;
    check("rst_ack",   64'(bus.wbm_ack_i),   64'd0);
    check("rst_err",   64'(bus.wbm_err_i),   64'd0);
    check("rst_stall", 64'(bus.wbm_stall_i), 64'd0);
    check("rst_cyc",   64'(bus.wbs_cyc_i),   64'd0);
    check("rst_dat",   64'(bus.wbm_dat_i),   64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Write to 0x13: slave 1, local address 3; a slave ack while idle is ignored
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h13; wdat = 32'hA5A5_0001; sel = 4'hF;
    s_dat = 64'hDEAD_BEEF_0BAD_F00D; man_ack = 2'b10; #1;
    check("wr_cyc",     64'(bus.wbs_cyc_i),   64'h2);
    check("wr_adr",     64'(bus.wbs_adr_i),   64'h3);
    check("wr_dat",     64'(bus.wbs_dat_i),   64'hA5A5_0001);
    check("wr_stall",   64'(bus.wbm_stall_i), 64'd0);
    check("idle_ack",   64'(bus.wbm_ack_i),   64'd0);
    @(negedge clk); stb = 1'b0; we = 1'b0; man_ack = 2'b10; #1;
    check("wr_ack",     64'(bus.wbm_ack_i),   64'd1);
    check("wr_rdat",    64'(bus.wbm_dat_i),   64'hDEAD_BEEF);
    @(negedge clk); man_ack = '0; #1;
    check("wr_ack_end", 64'(bus.wbm_ack_i),   64'd0);

    // Six back-to-back reads to slave 0 with 6-cycle ack latency
    s_dat = '0; auto_en = 1'b1; issued = 0; acks = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      stb = (issued < 6); we = 1'b0; adr = 32'(issued); #1;
      if (stb && !bus.wbm_stall_i) begin
        acc_at[issued] = c;
        issued++;
      end
      if (bus.wbm_ack_i) begin
        check("pipe_rdat", 64'(bus.wbm_dat_i), 64'(32'h1000 + 32'(acks)));
        acks++;
      end
    end
    auto_en = 1'b0; stb = 1'b0;
    check("pipe_issued", 64'(issued), 64'd6);
    check("pipe_acks",   64'(acks),   64'd6);
    for (int i = 0; i < 6; i++) check("pipe_acc_cycle", 64'(acc_at[i]), 64'(exp_acc[i]));

    // Slave 0 pending, request to slave 1 must wait for the slave-0 ack
    @(negedge clk); stb = 1'b1; adr = 32'h05; s_dat = 64'h2222_2222_1111_1111; #1;
    check("cf_first",  64'(bus.wbm_stall_i), 64'd0);
    @(negedge clk); adr = 32'h12; #1;
    check("cf_stall",  64'(bus.wbm_stall_i), 64'd1);
    check("cf_cyc",    64'(bus.wbs_cyc_i),   64'h1);
    check("cf_stb",    64'(bus.wbs_stb_i),   64'd0);
    @(negedge clk); #1;
    check("cf_stall2", 64'(bus.wbm_stall_i), 64'd1);
    @(negedge clk); man_ack = 2'b01; #1;
    check("cf_ack0",   64'(bus.wbm_ack_i),   64'd1);
    check("cf_dat0",   64'(bus.wbm_dat_i),   64'h1111_1111);
    check("cf_stall3", 64'(bus.wbm_stall_i), 64'd1);
    @(negedge clk); man_ack = '0; #1;
    check("cf_go",     64'(bus.wbm_stall_i), 64'd0);
    check("cf_cyc1",   64'(bus.wbs_cyc_i),   64'h2);
    @(negedge clk); stb = 1'b0; man_ack = 2'b10; #1;
    check("cf_ack1",   64'(bus.wbm_ack_i),   64'd1);
    check("cf_dat1",   64'(bus.wbm_dat_i),   64'h2222_2222);
    @(negedge clk); man_ack = '0;

    // Unmapped address 0x50: no slave cycle, err one cycle after accept
    stb = 1'b1; adr = 32'h50; #1;
    check("um_cyc",    64'(bus.wbs_cyc_i),   64'd0);
    check("um_stall",  64'(bus.wbm_stall_i), 64'd0);
    check("um_err0",   64'(bus.wbm_err_i),   64'd0);
    @(negedge clk); stb = 1'b0; #1;
    check("um_err",    64'(bus.wbm_err_i),   64'd1);
    check("um_dat",    64'(bus.wbm_dat_i),   64'd0);
    @(negedge clk); #1;
    check("um_err_end", 64'(bus.wbm_err_i),  64'd0);

    // Slave 0 never acks; a slave-1 request waits behind it
    @(negedge clk); stb = 1'b1; adr = 32'h01; #1;
    check("hang_acc", 64'(bus.wbm_stall_i), 64'd0);
    err_at = -1;
`ifdef WBX_TIMEOUT_EN
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); adr = 32'h10; stb = 1'b1; #1;
      if (err_at < 0 && bus.wbm_err_i) begin
        err_at = c;
        check("wd_abort_cyc", 64'(bus.wbs_cyc_i), 64'd0);
      end else if (err_at >= 0) begin
        check("wd_release", 64'(bus.wbm_stall_i), 64'd0);
        check("wd_newcyc",  64'(bus.wbs_cyc_i),   64'h2);
        break;
      end
    end
    check("wd_err_cycle", 64'(err_at), 64'd17);
`else
    err_cnt = 0; stall_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); adr = 32'h10; stb = 1'b1; #1;
      if (bus.wbm_err_i) err_cnt++;
      if (bus.wbm_stall_i) stall_cnt++;
    end
    check("nowd_err",   64'(err_cnt),   64'd0);
    check("nowd_stall", 64'(stall_cnt), 64'd40);
`endif
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    @(negedge clk); cyc = 1'b1;

    // Two pending, cyc dropped: late acks are ignored and the lock is freed
    @(negedge clk); stb = 1'b1; adr = 32'h02; #1;
    check("cd_acc1", 64'(bus.wbm_stall_i), 64'd0);
    @(negedge clk); adr = 32'h03; #1;
    check("cd_acc2", 64'(bus.wbm_stall_i), 64'd0);
    @(negedge clk); cyc = 1'b0; stb = 1'b0; man_ack = 2'b01; #1;
    check("cd_ack_low",  64'(bus.wbm_ack_i), 64'd0);
    check("cd_cyc_low",  64'(bus.wbs_cyc_i), 64'd0);
    @(negedge clk); cyc = 1'b1; man_ack = 2'b01; #1;
    check("cd_late_ack", 64'(bus.wbm_ack_i), 64'd0);
    @(negedge clk); man_ack = '0; stb = 1'b1; adr = 32'h10; #1;
    check("cd_free",     64'(bus.wbm_stall_i), 64'd0);
    check("cd_cyc1",     64'(bus.wbs_cyc_i),   64'h2);
    @(negedge clk); adr = 32'h11; #1;

    // Reset mid-transfer: outputs drop at once, dropped requests never return
    @(negedge clk); man_ack = 2'b10; rst_n = 1'b0; #1;
    check("mr_cyc",   64'(bus.wbs_cyc_i),   64'd0);
    check("mr_stb",   64'(bus.wbs_stb_i),   64'd0);
    check("mr_adr",   64'(bus.wbs_adr_i),   64'd0);
    check("mr_stall", 64'(bus.wbm_stall_i), 64'd0);
    check("mr_ack",   64'(bus.wbm_ack_i),   64'd0);
    check("mr_err",   64'(bus.wbm_err_i),   64'd0);
    check("mr_dat",   64'(bus.wbm_dat_i),   64'd0);
    @(negedge clk); rst_n = 1'b1; stb = 1'b0; man_ack = 2'b10; #1;
    check("mr_no_ack", 64'(bus.wbm_ack_i), 64'd0);
    @(negedge clk); cyc = 1'b0; man_ack = '0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
